mvb_fifox_rr_scheduler: RTL and testbench
=========================================

Name: mvb_fifox_rr_scheduler

Overview:
- Shares the single-item MVB write port of one FIFOX between RX_PORTS independent single-item MVB requesters.
- Uses round-robin arbitration with a bounded burst per grant.
- Gates new grants on the FIFOX almost-full flag.
- Drives the FIFOX write side through one registered output stage, and tags each item with its source port index.

Parameters:
RX_PORTS, 4, number of requesting MVB channels (>=2)
DATA_WIDTH, 64, item width on every RX channel and on TX
MAX_BURST, 4, max consecutive items granted to one port while others request (>=1)
SRC_WIDTH, log2(RX_PORTS), width of TX_SRC (min 1)

Ports:
CLK  in  1  clock; single clock domain
RESET  in  1  synchronous, active-high reset
RX_DATA  in  RX_PORTS*DATA_WIDTH  item of port i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
RX_VLD  in  RX_PORTS  item-valid per port
RX_SRC_RDY  in  RX_PORTS  source ready per port
RX_DST_RDY  out  RX_PORTS  destination ready per port
TX_DATA  out  DATA_WIDTH  item toward FIFOX write port
TX_SRC  out  SRC_WIDTH  index of port that supplied TX_DATA
TX_VLD  out  1  item-valid; always 1 when TX_SRC_RDY=1
TX_SRC_RDY  out  1  output register holds an item
TX_DST_RDY  in  1  FIFOX accepts
FIFO_AFULL  in  1  FIFOX almost-full; blocks new grants

Behaviour:
- RX handshake on port i: RX_SRC_RDY[i] & RX_DST_RDY[i]. TX handshake: TX_SRC_RDY & TX_DST_RDY.
- Request: req[i] = RX_SRC_RDY[i] & RX_VLD[i].
- Empty words: port i with RX_SRC_RDY=1 and RX_VLD=0 gets RX_DST_RDY[i]=1 combinationally in the same cycle.
  - The word is discarded and does not take part in arbitration.
  - Discard happens regardless of FIFO_AFULL or output-register state.
- Register free: free = !TX_SRC_RDY | TX_DST_RDY.
- Take: take = free & !FIFO_AFULL & (req != 0).
- Grant: exactly one port g, combinational, at most one RX_DST_RDY among requesting ports.
  - RX_DST_RDY[g] = take; all other requesting ports see 0.
- Arbiter state: holder h (SRC_WIDTH bits) and burst_cnt (0..MAX_BURST-1).
- Grant selection:
  - Keep h if req[h] = 1 and either burst_cnt < MAX_BURST-1 or no other port requests.
  - Otherwise g = first requesting port scanning h+1, h+2, ... with wrap, ending at h.
- State update occurs only on a cycle where take = 1:
  - g == h: burst_cnt <= min(burst_cnt+1, MAX_BURST-1).
  - g != h: h <= g; burst_cnt <= 0.
  - When the holder continues only because it is the lone requester, burst_cnt saturates at MAX_BURST-1; a switch occurs as soon as another port requests.
- MAX_BURST=1 gives pure round-robin.
- Output register:
  - On take: TX_DATA <= RX_DATA[g], TX_SRC <= g, TX_SRC_RDY <= 1, TX_VLD <= 1.
  - On TX handshake without take: TX_SRC_RDY <= 0, TX_VLD <= 0.
  - Otherwise hold.
  - Latency RX handshake -> TX_SRC_RDY = 1 cycle.
  - Full throughput: 1 item/cycle while TX_DST_RDY=1 and FIFO_AFULL=0.
- FIFO_AFULL=1: no new grant that cycle. An item already in the register is still presented and drains on TX_DST_RDY. FIFO_AFULL is used combinationally, not registered.
- TX_DATA/TX_SRC stay stable while TX_SRC_RDY=1 and TX_DST_RDY=0.
- Reset (also mid-operation): TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, TX_SRC=0, h=RX_PORTS-1 (port 0 wins first), burst_cnt=0.
  - An item held in the register is dropped.
  - RX_DST_RDY=0 for all ports during RESET.
- Simultaneous TX handshake and take: register reloads with the new item; TX_SRC_RDY stays 1.
- Ports must not drop RX_SRC_RDY before handshake (MVB rule). The bench flags violations via property checks on every RX port, TX, and the status/AFULL path.

Test Plan:
- RX_PORTS=4, MAX_BURST=1, all ports stream continuously, TX_DST_RDY=1 -> TX_SRC sequence 0,1,2,3,0,1,... one item per cycle; first TX_SRC_RDY one cycle after first RX handshake.
- MAX_BURST=4, ports 1 and 3 stream continuously -> TX_SRC = 1,1,1,1,3,3,3,3,1,...; with only port 2 active, 10 consecutive items from port 2 with no gaps.
- Port 0 streaming, FIFO_AFULL=1 for cycles 5..9 -> no RX_DST_RDY during cycles 5..9; register drains exactly one pending item; resumes cycle 10 with no loss or duplication (scoreboard order per port preserved).
- TX_DST_RDY toggled randomly 50% with all ports active -> TX_DATA/TX_SRC stable while stalled; every item appears exactly once; per-port order preserved.
- Port 2 sends SRC_RDY=1, VLD=0 while FIFO_AFULL=1 -> RX_DST_RDY[2]=1 same cycle, nothing on TX.
- RESET asserted one cycle while TX_SRC_RDY=1 and TX_DST_RDY=0 -> next cycle TX_SRC_RDY=0; after release with all ports requesting, first grant goes to port 0.

Source files
------------

// File: rtl/mvb_fifox_rr_scheduler_if.sv
// mvb_fifox_rr_scheduler_if: bundle of RX_PORTS MVB requesters, the FIFOX write side and the FIFOX almost-full flag
//   master: requesters + FIFOX (drives rx_*, tx_dst_rdy, fifo_afull)
//   slave : scheduler (drives rx_dst_rdy, tx_*)
interface mvb_fifox_rr_scheduler_if #(
    parameter int RX_PORTS   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int SRC_WIDTH  = (RX_PORTS > 1) ? $clog2(RX_PORTS) : 1
);
    logic [RX_PORTS*DATA_WIDTH-1:0] rx_data;
    logic [RX_PORTS-1:0]            rx_vld;
    logic [RX_PORTS-1:0]            rx_src_rdy;
    logic [RX_PORTS-1:0]            rx_dst_rdy;
    logic [DATA_WIDTH-1:0]          tx_data;
    logic [SRC_WIDTH-1:0]           tx_src;
    logic                           tx_vld;
    logic                           tx_src_rdy;
    logic                           tx_dst_rdy;
    logic                           fifo_afull;
    modport master (
        output rx_data, rx_vld, rx_src_rdy, tx_dst_rdy, fifo_afull,
        input  rx_dst_rdy, tx_data, tx_src, tx_vld, tx_src_rdy
    );
    modport slave (
        input  rx_data, rx_vld, rx_src_rdy, tx_dst_rdy, fifo_afull,
        output rx_dst_rdy, tx_data, tx_src, tx_vld, tx_src_rdy
    );
endinterface

// File: rtl/mvb_fifox_rr_scheduler.sv
// mvb_fifox_rr_scheduler: round-robin, burst-bounded sharing of one FIFOX write port among RX_PORTS MVB requesters
//   CLK, RESET : single clock, synchronous active-high reset
//   bus.rx_*   : per-port items in, rx_dst_rdy grants (empty words acked at once)
//   bus.tx_*   : registered item toward FIFOX, tagged with source port index
//   bus.fifo_afull : blocks new grants combinationally
module mvb_fifox_rr_scheduler #(
    parameter int RX_PORTS   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4,
    parameter int SRC_WIDTH  = (RX_PORTS > 1) ? $clog2(RX_PORTS) : 1
) (
    input logic CLK,
    input logic RESET,
    mvb_fifox_rr_scheduler_if.slave bus
);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic [SRC_WIDTH-1:0] h;
    logic [SRC_WIDTH-1:0] g;
    logic [BW-1:0]        burst_cnt;
    logic                 fresh;
    logic [RX_PORTS-1:0]  req;
    logic                 others;
    logic                 keep;
    logic                 free;
    logic                 take;

    assign req    = bus.rx_src_rdy & bus.rx_vld;
    assign free   = !bus.tx_src_rdy | bus.tx_dst_rdy;
    assign take   = !RESET & free & !bus.fifo_afull & (|req);
    assign others = |(req & ~(RX_PORTS'(1) << h));
    // fresh marks "no holder yet" after reset so the scan starting at h+1 lets port 0 win first
    assign keep   = !fresh && req[h] && (int'(burst_cnt) < MAX_BURST - 1 || !others);

    // descending loop: the smallest offset from h+1 is assigned last and wins
    always_comb begin
        g = h;
        if (!keep)
            for (int k = RX_PORTS; k >= 1; k--)
                if (req[(int'(h) + k) % RX_PORTS]) g = SRC_WIDTH'((int'(h) + k) % RX_PORTS);
    end

    always_comb begin
        bus.rx_dst_rdy = RESET ? '0 : bus.rx_src_rdy & ~bus.rx_vld;
        if (take) bus.rx_dst_rdy[g] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            h              <= SRC_WIDTH'(RX_PORTS - 1);
            burst_cnt      <= '0;
            fresh          <= 1'b1;
            bus.tx_data    <= '0;
            bus.tx_src     <= '0;
            bus.tx_src_rdy <= 1'b0;
            bus.tx_vld     <= 1'b0;
        end else if (take) begin
            h              <= g;
            fresh          <= 1'b0;
            burst_cnt      <= (fresh || g != h) ? '0 :
                              (int'(burst_cnt) < MAX_BURST - 1) ? burst_cnt + 1'b1 : burst_cnt;
            bus.tx_data    <= bus.rx_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
            bus.tx_src     <= g;
            bus.tx_src_rdy <= 1'b1;
            bus.tx_vld     <= 1'b1;
        end else if (bus.tx_dst_rdy) begin
            bus.tx_src_rdy <= 1'b0;
            bus.tx_vld     <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mvb_fifox_rr_scheduler.sv
// tb_mvb_fifox_rr_scheduler: scoreboard bench for a MAX_BURST=1 (u0) and a MAX_BURST=4 (u1) scheduler
module tb_mvb_fifox_rr_scheduler;
    localparam int P = 4;
    localparam int W = 64;
    localparam int S = 2;

    typedef struct {
        logic [S-1:0] src;
        logic [W-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [P-1:0]   src_rdy [2];
    logic [P-1:0]   vld [2];
    logic [P*W-1:0] data [2];
    logic           txr;
    logic           af;
    logic [P-1:0]   dst_rdy [2];
    logic [W-1:0]   tx_data [2];
    logic [S-1:0]   tx_src [2];
    logic           tx_vld [2];
    logic           tx_src_rdy [2];

    int   seq [2][P];
    int   rem [2][P];
    logic [P-1:0] pend [2];
    int   empty_port = -1;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    mvb_fifox_rr_scheduler_if #(.RX_PORTS(P), .DATA_WIDTH(W), .SRC_WIDTH(S)) b0 ();
    mvb_fifox_rr_scheduler_if #(.RX_PORTS(P), .DATA_WIDTH(W), .SRC_WIDTH(S)) b1 ();

    mvb_fifox_rr_scheduler #(.RX_PORTS(P), .DATA_WIDTH(W), .MAX_BURST(1), .SRC_WIDTH(S)) u0 (
        .CLK(clk), .RESET(rst), .bus(b0)
    );
    mvb_fifox_rr_scheduler #(.RX_PORTS(P), .DATA_WIDTH(W), .MAX_BURST(4), .SRC_WIDTH(S)) u1 (
        .CLK(clk), .RESET(rst), .bus(b1)
    );

    assign b0.rx_src_rdy = src_rdy[0];
    assign b0.rx_vld     = vld[0];
    assign b0.rx_data    = data[0];
    assign b0.tx_dst_rdy = txr;
    assign b0.fifo_afull = af;
    assign b1.rx_src_rdy = src_rdy[1];
    assign b1.rx_vld     = vld[1];
    assign b1.rx_data    = data[1];
    assign b1.tx_dst_rdy = txr;
    assign b1.fifo_afull = af;
    assign dst_rdy[0]    = b0.rx_dst_rdy;
    assign tx_data[0]    = b0.tx_data;
    assign tx_src[0]     = b0.tx_src;
    assign tx_vld[0]     = b0.tx_vld;
    assign tx_src_rdy[0] = b0.tx_src_rdy;
    assign dst_rdy[1]    = b1.rx_dst_rdy;
    assign tx_data[1]    = b1.tx_data;
    assign tx_src[1]     = b1.tx_src;
    assign tx_vld[1]     = b1.tx_vld;
    assign tx_src_rdy[1] = b1.tx_src_rdy;

    function automatic logic [W-1:0] item(input int p, input int s);
        return {8'hA5, 24'(p), 32'(s)};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int p, input int s);
        exp_t e;
        e.src  = S'(p);
        e.data = item(p, s);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // inputs change on negedge; handshakes are sampled 1 time unit before the posedge
    task automatic step(input logic t, input logic a, input logic r);
        @(negedge clk);
        rst = r;
        txr = t;
        af  = a;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < P; i++) begin
                src_rdy[k][i] = (k == 1 && i == empty_port) || rem[k][i] > 0;
                vld[k][i]     = rem[k][i] > 0;
                data[k][i*W +: W] = item(i, seq[k][i]);
            end
            if ((pend[k] & ~src_rdy[k]) != 0) begin
                errors++;
                $display("FAIL src_rule: inst %0d dropped src_rdy %b before handshake", k, pend[k] & ~src_rdy[k]);
            end
        end
        #4;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < P; i++)
                if (src_rdy[k][i] && vld[k][i] && dst_rdy[k][i]) begin
                    seq[k][i]++;
                    rem[k][i]--;
                end
            pend[k] = src_rdy[k] & ~dst_rdy[k];
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) begin
            pend[k] = '0;
            for (int i = 0; i < P; i++) begin
                rem[k][i] = 0;
                seq[k][i] = 0;
            end
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
    endtask

    task automatic drain(input bit rnd, input int maxc);
        int c = 0;
        while (q0.size() + q1.size() != 0 && c < maxc) begin
            step(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
            c++;
        end
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d items still pending, required 0", q0.size() + q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    // monitor: pops the scoreboard on every TX handshake and checks TX/grant rules
    initial begin
        logic         stall [2];
        logic [W-1:0] pd [2];
        logic [S-1:0] ps [2];
        logic [P-1:0] gr;
        exp_t         e;
        stall[0] = 1'b0;
        stall[1] = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            for (int k = 0; k < 2; k++) begin
                if (!rst) begin
                    if (stall[k])
                        chk("tx_hold", {tx_src_rdy[k], tx_src[k], tx_data[k]}, {1'b1, ps[k], pd[k]});
                    if (tx_src_rdy[k] && !tx_vld[k]) begin
                        errors++;
                        $display("FAIL tx_vld: inst %0d got 0, expected 1", k);
                    end
                    gr = dst_rdy[k] & src_rdy[k] & vld[k];
                    if ($countones(gr) > 1 || (af && gr != 0)) begin
                        errors++;
                        $display("FAIL grant_rule: inst %0d grants %b afull %b", k, gr, af);
                    end
                    if (tx_src_rdy[k] && txr) begin
                        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL tx_unexpected: inst %0d got src %0d data %0h, expected nothing", k, tx_src[k], tx_data[k]);
                        end else begin
                            if (k == 0) e = q0.pop_front();
                            else e = q1.pop_front();
                            chk(k == 0 ? "tx_item_u0" : "tx_item_u1", {tx_src[k], tx_data[k]}, {e.src, e.data});
                        end
                    end
                end
                stall[k] = !rst && tx_src_rdy[k] && !txr;
                pd[k]    = tx_data[k];
                ps[k]    = tx_src[k];
            end
        end
    end

    initial begin
        txr = 1'b1;
        af  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            src_rdy[k] = '0;
            vld[k]     = '0;
            data[k]    = '0;
        end
        do_reset();
        for (int k = 0; k < 2; k++)
            chk("reset_state", {tx_src_rdy[k], tx_vld[k], tx_src[k], tx_data[k]}, '0);

        // MAX_BURST=1, all ports streaming: 0,1,2,3 repeating, one item per cycle
        for (int i = 0; i < P; i++) rem[0][i] = 3;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < P; i++) push(0, i, r);
        step(1'b1, 1'b0, 1'b0);
        chk("t1_first_grant", dst_rdy[0], 4'b0001);
        chk("t1_no_early_tx", tx_src_rdy[0], 0);
        for (int j = 0; j < 12; j++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("t1_stream_vld", tx_src_rdy[0], 1);
            chk("t1_stream_src", tx_src[0], j % 4);
        end
        drain(1'b0, 20);

        // MAX_BURST=4, ports 1 and 3: bursts of four
        do_reset();
        rem[1][1] = 8;
        rem[1][3] = 8;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) push(1, 1, r*4 + j);
            for (int j = 0; j < 4; j++) push(1, 3, r*4 + j);
        end
        drain(1'b0, 40);

        // lone requester: ten items back to back
        rem[1][2] = 10;
        for (int j = 0; j < 10; j++) push(1, 2, j);
        step(1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 1'b0, 1'b0);
            chk("t2_gapless_vld", tx_src_rdy[1], 1);
            chk("t2_gapless_src", tx_src[1], 2);
        end
        drain(1'b0, 20);

        // almost-full window on cycles 5..9
        do_reset();
        rem[1][0] = 10;
        for (int j = 0; j < 10; j++) push(1, 0, j);
        for (int c = 0; c < 15; c++) begin
            step(1'b1, 1'(c >= 5 && c <= 9), 1'b0);
            if (c >= 5 && c <= 9) chk("t3_afull_block", dst_rdy[1], 0);
            if (c == 5) chk("t3_drain_one", tx_src_rdy[1], 1);
            if (c >= 6 && c <= 9) chk("t3_reg_empty", tx_src_rdy[1], 0);
            if (c == 10) chk("t3_resume", dst_rdy[1], 4'b0001);
        end
        drain(1'b0, 20);

        // random backpressure, all ports
        do_reset();
        for (int i = 0; i < P; i++) rem[1][i] = 8;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < P; i++)
                for (int j = 0; j < 4; j++) push(1, i, r*4 + j);
        drain(1'b1, 400);

        // reset while an item is stalled in the register
        do_reset();
        for (int i = 0; i < P; i++) rem[1][i] = 2;
        push(1, 0, 1);
        for (int i = 1; i < P; i++) begin
            push(1, i, 0);
            push(1, i, 1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("t5_grant0", dst_rdy[1], 4'b0001);
        step(1'b0, 1'b0, 1'b0);
        chk("t5_held", tx_src_rdy[1], 1);
        chk("t5_no_grant_stalled", dst_rdy[1], 0);
        step(1'b0, 1'b0, 1'b1);
        chk("t5_rst_dst_rdy", dst_rdy[1], 0);
        step(1'b0, 1'b0, 1'b0);
        chk("t5_dropped", tx_src_rdy[1], 0);
        chk("t5_first_after_rst", dst_rdy[1], 4'b0001);
        drain(1'b0, 40);

        // empty word under almost-full
        do_reset();
        empty_port = 2;
        step(1'b1, 1'b1, 1'b0);
        chk("t6_empty_ack", dst_rdy[1], 4'b0100);
        chk("t6_no_tx", tx_src_rdy[1], 0);
        empty_port = -1;
        step(1'b1, 1'b0, 1'b0);
        chk("t6_still_empty", tx_src_rdy[1], 0);
        step(1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
